seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Scan scheduler for a multiplexed 6-digit seven-segment display.
// Frame-consistent shadow digits, anti-ghost blanking, PWM and zero blanking.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 6,
    parameter int SLOT_CYCLES  = 4096,
    parameter int BLANK_CYCLES = 256,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] digits_in,
    input  logic [5:0]  dp_in,
    input  logic        blank_lz,
    input  logic [2:0]  brightness,
    input  logic        load_req,
    output logic        load_ack,
    output logic        frame_start,
    output logic [2:0]  seg7_sel,
    output logic [6:0]  seg7_out,
    output logic        dpt_out
);

    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W:0]   BLANK_C   = (CNT_W+1)'(BLANK_CYCLES);
    localparam logic [2:0]       SEL_FIRST = 3'd5;
    localparam logic [2:0]       SEL_LAST  = 3'(6 - NUM_DIGITS);
    localparam int               SPAN      = SLOT_CYCLES - BLANK_CYCLES;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        ON    = 2'd1,
        OFF   = 2'd2
    } phase_t;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] on_q;
    logic [23:0]      shadow_d;
    logic [5:0]       shadow_dp;
    phase_t           phase_q;

    logic             wrap;
    logic             load;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       sel_n;
    logic [CNT_W-1:0] on_len;
    logic [CNT_W:0]   ext_n;
    logic [CNT_W:0]   on_end;
    logic [23:0]      dig_n;
    logic [5:0]       dp_n;
    logic [2:0]       k;
    logic [3:0]       digit;
    logic             lz_zero;
    logic             blanked;
    phase_t           phase_n;

    function automatic logic [CNT_W-1:0] on_calc(input logic [2:0] b);
        logic [CNT_W+3:0] p;
        p = (CNT_W+4)'(SPAN) * (CNT_W+4)'(b) + (CNT_W+4)'(SPAN);
        return p[CNT_W+2:3];
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Outputs are registered from next-cycle state so they line up with cnt.
    always_comb begin
        wrap   = (cnt == C_LAST);
        load   = wrap && (seg7_sel == SEL_LAST) && load_req;
        cnt_n  = wrap ? '0 : cnt + 1'b1;
        sel_n  = seg7_sel;
        if (wrap) begin
            sel_n = (seg7_sel == SEL_LAST) ? SEL_FIRST : seg7_sel - 3'd1;
        end
        on_len = (cnt == '0) ? on_calc(brightness) : on_q;
        ext_n  = {1'b0, cnt_n};
        on_end = BLANK_C + {1'b0, on_len};
        dig_n  = load ? digits_in : shadow_d;
        dp_n   = load ? dp_in : shadow_dp;
        k      = SEL_FIRST - sel_n;
        digit  = dig_n[{k, 2'b00} +: 4];

        lz_zero = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < NUM_DIGITS && 3'(i) >= k && dig_n[i*4 +: 4] != 4'd0) begin
                lz_zero = 1'b0;
            end
        end
        blanked = blank_lz && (k != 3'd0) && lz_zero;

        phase_n = BLANK;
        unique case (phase_q)
            BLANK: begin
                if (ext_n < BLANK_C) phase_n = BLANK;
                else if (ext_n < on_end) phase_n = ON;
                else phase_n = OFF;
            end
            ON: begin
                if (wrap) phase_n = BLANK;
                else if (ext_n < on_end) phase_n = ON;
                else phase_n = OFF;
            end
            OFF: phase_n = wrap ? BLANK : OFF;
            default: phase_n = BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            on_q        <= '0;
            shadow_d    <= '0;
            shadow_dp   <= '0;
            phase_q     <= BLANK;
            seg7_sel    <= SEL_FIRST;
            seg7_out    <= '0;
            dpt_out     <= 1'b0;
            load_ack    <= 1'b0;
            frame_start <= 1'b1;
        end else begin
            cnt      <= cnt_n;
            seg7_sel <= sel_n;
            phase_q  <= phase_n;
            if (cnt == '0) begin
                on_q <= on_len;
            end
            if (load) begin
                shadow_d  <= digits_in;
                shadow_dp <= dp_in;
            end
            load_ack    <= load;
            frame_start <= (cnt_n == '0) && (sel_n == SEL_FIRST);
            seg7_out    <= (phase_n == ON && !blanked) ? decode(digit) : 7'd0;
            dpt_out     <= (phase_n == ON) && dp_n[k];
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with short slots (16 cycles, 4 blank).
// Two instances: a full 6-digit scan and a 4-digit scan.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] digits_in;
    logic [5:0]  dp_in;
    logic        blank_lz;
    logic [2:0]  brightness;
    logic        load_req;

    logic        load_ack, frame_start, dpt_out;
    logic [2:0]  seg7_sel;
    logic [6:0]  seg7_out;
    logic        load_ack4, frame_start4, dpt_out4;
    logic [2:0]  seg7_sel4;
    logic [6:0]  seg7_out4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS(6), .SLOT_CYCLES(16), .BLANK_CYCLES(4), .CNT_W(16)
    ) u6 (
        .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
        .blank_lz(blank_lz), .brightness(brightness), .load_req(load_req),
        .load_ack(load_ack), .frame_start(frame_start),
        .seg7_sel(seg7_sel), .seg7_out(seg7_out), .dpt_out(dpt_out)
    );

    seg7_scan_ctrl #(
        .NUM_DIGITS(4), .SLOT_CYCLES(16), .BLANK_CYCLES(4), .CNT_W(16)
    ) u4 (
        .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
        .blank_lz(blank_lz), .brightness(brightness), .load_req(load_req),
        .load_ack(load_ack4), .frame_start(frame_start4),
        .seg7_sel(seg7_sel4), .seg7_out(seg7_out4), .dpt_out(dpt_out4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Starts in the c=0 window of sel 5; pat/dpm are indexed by digit k.
    task automatic check_frame(
        input string      tag,
        input logic [6:0] pat [6],
        input logic [5:0] dpm,
        input int         on_len,
        input logic       ack0,
        input int         n,
        input int         raise_at,
        input logic [23:0] rd,
        input logic [5:0] rdp,
        input int         drop_at
    );
        for (int i = 0; i < n; i++) begin
            int s, c;
            logic lit;
            s   = i / 16;
            c   = i % 16;
            lit = (c >= 4) && (c < 4 + on_len);
            chk($sformatf("%s sel i=%0d", tag, i), 32'(seg7_sel), 32'(5 - s));
            chk($sformatf("%s seg i=%0d", tag, i), 32'(seg7_out),
                32'(lit ? pat[s] : 7'd0));
            chk($sformatf("%s dp i=%0d", tag, i), 32'(dpt_out),
                32'(lit && dpm[s]));
            chk($sformatf("%s fs i=%0d", tag, i), 32'(frame_start),
                32'(i == 0));
            chk($sformatf("%s ack i=%0d", tag, i), 32'(load_ack),
                32'((i == 0) ? ack0 : 1'b0));
            if (i == drop_at) load_req = 1'b0;
            if (i == raise_at) begin
                digits_in = rd;
                dp_in     = rdp;
                load_req  = 1'b1;
            end
            tick();
        end
    endtask

    logic [6:0] p_zero [6];
    logic [6:0] p_num  [6];
    logic [6:0] p_lz   [6];
    logic [6:0] p_lz0  [6];
    logic [6:0] p_dec  [6];

    initial begin
        p_zero = '{7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E};
        p_num  = '{7'b1011111, 7'b1011011, 7'b0110011,
                   7'b1111001, 7'b1101101, 7'b0110000};
        p_lz   = '{7'b1111110, 7'b1101101, 7'b0110000, 7'd0, 7'd0, 7'd0};
        p_lz0  = '{7'b1111110, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        p_dec  = '{7'd0, 7'b1111111, 7'h7E, 7'h7E, 7'h7E, 7'h7E};

        reset = 1'b1; digits_in = '0; dp_in = '0; blank_lz = 1'b0;
        brightness = 3'd7; load_req = 1'b0;
        tick();
        tick();
        chk("rst sel", 32'(seg7_sel), 32'd5);
        chk("rst seg", 32'(seg7_out), 32'd0);
        chk("rst dp", 32'(dpt_out), 32'd0);
        chk("rst ack", 32'(load_ack), 32'd0);
        reset = 1'b0;

        check_frame("scan", p_zero, 6'd0, 12, 1'b0, 96, -1, '0, '0, -1);
        brightness = 3'd3;
        check_frame("bri3", p_zero, 6'd0, 6, 1'b0, 96, -1, '0, '0, -1);
        brightness = 3'd0;
        check_frame("bri0", p_zero, 6'd0, 1, 1'b0, 96, -1, '0, '0, -1);
        brightness = 3'd7;
        check_frame("ldreq", p_zero, 6'd0, 12, 1'b0, 96,
                    40, 24'h123456, 6'd0, -1);
        check_frame("ldshow", p_num, 6'd0, 12, 1'b1, 96,
                    -1, '0, '0, 0);
        check_frame("lddrop", p_num, 6'd0, 12, 1'b0, 96,
                    10, 24'h000120, 6'd0, 90);
        check_frame("keep", p_num, 6'd0, 12, 1'b0, 96,
                    0, 24'h000120, 6'd0, -1);
        blank_lz = 1'b1;
        check_frame("lz", p_lz, 6'd0, 12, 1'b1, 96,
                    1, 24'h000000, 6'd0, 0);
        check_frame("lzall", p_lz0, 6'd0, 12, 1'b1, 96,
                    1, 24'h00008A, 6'b000101, 0);
        blank_lz = 1'b0;
        check_frame("dec", p_dec, 6'b000101, 12, 1'b1, 96,
                    -1, '0, '0, 0);

        check_frame("prerst", p_dec, 6'b000101, 12, 1'b0, 55,
                    1, 24'h999999, 6'h3F, -1);
        chk("mid c7 sel", 32'(seg7_sel), 32'd2);
        reset = 1'b1;
        tick();
        chk("mrst sel", 32'(seg7_sel), 32'd5);
        chk("mrst seg", 32'(seg7_out), 32'd0);
        chk("mrst ack", 32'(load_ack), 32'd0);
        chk("mrst fs", 32'(frame_start), 32'd1);
        reset = 1'b0;
        load_req = 1'b0;
        check_frame("postrst", p_zero, 6'd0, 12, 1'b0, 96, -1, '0, '0, -1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 128; i++) begin
            chk($sformatf("nd4 sel i=%0d", i), 32'(seg7_sel4),
                32'(5 - ((i / 16) % 4)));
            chk($sformatf("nd4 fs i=%0d", i), 32'(frame_start4),
                32'(i % 64 == 0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
